// File: rtl/iq_demodulator.sv
// Single-tone IQ demodulator: mixes the sample stream with a LUT-based NCO and
// integrates I/Q over fixed windows, reporting sums and a magnitude estimate.
module iq_demodulator #(
  parameter int STEP_FREQ = 100_000_000,
  parameter int FREQUENCY = 13_560_000,
  parameter int WINDOW    = 256,
  localparam int ACC_W    = 32 + $clog2(WINDOW)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic signed [15:0]      sample_in,
  input  logic                    sample_valid_in,
  input  logic                    sync_in,
  output logic signed [ACC_W-1:0] i_out,
  output logic signed [ACC_W-1:0] q_out,
  output logic        [ACC_W:0]   mag_out,
  output logic                    valid_out
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [63:0] INCR_WIDE =
    ((64'(FREQUENCY) << 32) + 64'(STEP_FREQ / 2)) / 64'(STEP_FREQ);
  localparam logic [31:0]      PHASE_INCR = INCR_WIDE[31:0];
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WINDOW - 1);

  // First quarter of round(32767*sin(2*pi*n/64)); the rest follows by symmetry.
  function automatic logic signed [15:0] quarter_sin(input logic [4:0] n);
    logic signed [15:0] r;
    r = 16'sd0;
    case (n)
      5'd0:  r = 16'sd0;
      5'd1:  r = 16'sd3212;
      5'd2:  r = 16'sd6393;
      5'd3:  r = 16'sd9512;
      5'd4:  r = 16'sd12539;
      5'd5:  r = 16'sd15446;
      5'd6:  r = 16'sd18204;
      5'd7:  r = 16'sd20787;
      5'd8:  r = 16'sd23170;
      5'd9:  r = 16'sd25329;
      5'd10: r = 16'sd27245;
      5'd11: r = 16'sd28898;
      5'd12: r = 16'sd30273;
      5'd13: r = 16'sd31356;
      5'd14: r = 16'sd32137;
      5'd15: r = 16'sd32609;
      5'd16: r = 16'sd32767;
      default: r = 16'sd0;
    endcase
    return r;
  endfunction

  function automatic logic signed [15:0] lut_sin(input logic [5:0] idx);
    logic [4:0]         m;
    logic [5:0]         mirror;
    logic signed [15:0] amp;
    m      = idx[4:0];
    mirror = 6'd32 - {1'b0, m};
    if (m <= 5'd16) amp = quarter_sin(m);
    else            amp = quarter_sin(mirror[4:0]);
    return idx[5] ? -amp : amp;
  endfunction

  logic        [31:0]      phase_q, phase_d;
  logic                    va_q, va_d;
  logic signed [15:0]      sample_a_q, sample_a_d;
  logic signed [15:0]      sin_a_q, sin_a_d;
  logic signed [15:0]      cos_a_q, cos_a_d;
  logic                    vb_q, vb_d;
  logic signed [31:0]      prod_i_q, prod_i_d;
  logic signed [31:0]      prod_q_q, prod_q_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic                    hold_v_q, hold_v_d;
  logic signed [ACC_W-1:0] hold_i_q, hold_i_d;
  logic signed [ACC_W-1:0] hold_q_q, hold_q_d;
  logic signed [ACC_W-1:0] i_q, i_d;
  logic signed [ACC_W-1:0] q_q, q_d;
  logic        [ACC_W:0]   mag_q, mag_d;
  logic                    valid_q, valid_d;

  logic        [31:0]      phase_base;
  logic        [5:0]       sin_idx, cos_idx;
  logic signed [31:0]      sample_ext, sin_ext, cos_ext;
  logic        [ACC_W-1:0] sum_i, sum_q;
  logic        [ACC_W-1:0] abs_i, abs_q, mag_max, mag_min;

  always_comb begin
    // A sync edge restarts the carrier, so a coincident sample sees phase 0.
    phase_base = sync_in ? 32'd0 : phase_q;
    sin_idx    = phase_base[31:26];
    cos_idx    = phase_base[31:26] + 6'd16;

    phase_d    = phase_base;
    va_d       = 1'b0;
    sample_a_d = sample_a_q;
    sin_a_d    = sin_a_q;
    cos_a_d    = cos_a_q;
    if (sample_valid_in) begin
      va_d       = 1'b1;
      sample_a_d = sample_in;
      sin_a_d    = lut_sin(sin_idx);
      cos_a_d    = lut_sin(cos_idx);
      phase_d    = phase_base + PHASE_INCR;
    end

    sample_ext = {{16{sample_a_q[15]}}, sample_a_q};
    sin_ext    = {{16{sin_a_q[15]}}, sin_a_q};
    cos_ext    = {{16{cos_a_q[15]}}, cos_a_q};
    vb_d       = va_q & ~sync_in;
    prod_i_d   = prod_i_q;
    prod_q_d   = prod_q_q;
    if (va_q) begin
      prod_i_d = sample_ext * cos_ext;
      prod_q_d = sample_ext * sin_ext;
    end

    sum_i    = acc_i_q + {{(ACC_W-32){prod_i_q[31]}}, prod_i_q};
    sum_q    = acc_q_q + {{(ACC_W-32){prod_q_q[31]}}, prod_q_q};
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    cnt_d    = cnt_q;
    hold_v_d = 1'b0;
    hold_i_d = hold_i_q;
    hold_q_d = hold_q_q;
    if (sync_in) begin
      acc_i_d = '0;
      acc_q_d = '0;
      cnt_d   = '0;
    end else if (vb_q) begin
      if (cnt_q == CNT_LAST) begin
        // Last sample of the window goes straight to the hold registers.
        hold_v_d = 1'b1;
        hold_i_d = sum_i;
        hold_q_d = sum_q;
        acc_i_d  = '0;
        acc_q_d  = '0;
        cnt_d    = '0;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end

    abs_i   = hold_i_q[ACC_W-1] ? -hold_i_q : hold_i_q;
    abs_q   = hold_q_q[ACC_W-1] ? -hold_q_q : hold_q_q;
    mag_max = (abs_i >= abs_q) ? abs_i : abs_q;
    mag_min = (abs_i >= abs_q) ? abs_q : abs_i;

    // The completed window is reported even if sync_in arrives now.
    valid_d = hold_v_q;
    i_d     = i_q;
    q_d     = q_q;
    mag_d   = mag_q;
    if (hold_v_q) begin
      i_d   = hold_i_q;
      q_d   = hold_q_q;
      mag_d = {1'b0, mag_max} + {3'b000, mag_min[ACC_W-1:2]}
            + {4'b0000, mag_min[ACC_W-1:3]};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase_q    <= '0;
      va_q       <= 1'b0;
      sample_a_q <= '0;
      sin_a_q    <= '0;
      cos_a_q    <= '0;
      vb_q       <= 1'b0;
      prod_i_q   <= '0;
      prod_q_q   <= '0;
      acc_i_q    <= '0;
      acc_q_q    <= '0;
      cnt_q      <= '0;
      hold_v_q   <= 1'b0;
      hold_i_q   <= '0;
      hold_q_q   <= '0;
      i_q        <= '0;
      q_q        <= '0;
      mag_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      va_q       <= va_d;
      sample_a_q <= sample_a_d;
      sin_a_q    <= sin_a_d;
      cos_a_q    <= cos_a_d;
      vb_q       <= vb_d;
      prod_i_q   <= prod_i_d;
      prod_q_q   <= prod_q_d;
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      cnt_q      <= cnt_d;
      hold_v_q   <= hold_v_d;
      hold_i_q   <= hold_i_d;
      hold_q_q   <= hold_q_d;
      i_q        <= i_d;
      q_q        <= q_d;
      mag_q      <= mag_d;
      valid_q    <= valid_d;
    end
  end

  assign i_out     = i_q;
  assign q_out     = q_q;
  assign mag_out   = mag_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_iq_demodulator.sv
// Directed bench for iq_demodulator: a behavioural model pushes expected window
// results with their due cycle; a negedge monitor pops and compares them.
module tb_iq_demodulator;

  localparam int STEP_FREQ = 64;
  localparam int FREQUENCY = 1;
  localparam int WINDOW    = 64;
  localparam int ACC_W     = 32 + $clog2(WINDOW);
  localparam longint M_INCR =
    ((longint'(FREQUENCY) <<< 32) + longint'(STEP_FREQ / 2)) / longint'(STEP_FREQ);

  logic                    clk_in = 1'b0;
  logic                    rst_n_in;
  logic signed [15:0]      sample_in;
  logic                    sample_valid_in;
  logic                    sync_in;
  logic signed [ACC_W-1:0] i_out;
  logic signed [ACC_W-1:0] q_out;
  logic        [ACC_W:0]   mag_out;
  logic                    valid_out;

  iq_demodulator #(
    .STEP_FREQ(STEP_FREQ),
    .FREQUENCY(FREQUENCY),
    .WINDOW   (WINDOW)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .sample_in      (sample_in),
    .sample_valid_in(sample_valid_in),
    .sync_in        (sync_in),
    .i_out          (i_out),
    .q_out          (q_out),
    .mag_out        (mag_out),
    .valid_out      (valid_out)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [ACC_W-1:0] exp_i_q[$];
  logic [ACC_W-1:0] exp_q_q[$];
  logic [ACC_W:0]   exp_mag_q[$];
  int               exp_cyc_q[$];

  longint      m_acc_i;
  longint      m_acc_q;
  int          m_cnt;
  logic [31:0] m_phase;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lut_m(input int n);
    real x;
    x = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(n) / 64.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return $rtoi(x - 0.5);
  endfunction

  task automatic model_clear();
    m_acc_i = 0;
    m_acc_q = 0;
    m_cnt   = 0;
    m_phase = 32'd0;
  endtask

  task automatic model_accept(input int s, input bit sync);
    int     idx;
    int     sn;
    int     cs;
    longint ai;
    longint aq;
    longint mx;
    longint mn;
    longint mag;
    if (sync) model_clear();
    idx = int'(m_phase[31:26]);
    sn  = lut_m(idx);
    cs  = lut_m((idx + 16) % 64);
    m_acc_i += longint'(s) * longint'(cs);
    m_acc_q += longint'(s) * longint'(sn);
    m_phase = m_phase + 32'(M_INCR);
    m_cnt++;
    if (m_cnt == WINDOW) begin
      ai  = (m_acc_i < 0) ? -m_acc_i : m_acc_i;
      aq  = (m_acc_q < 0) ? -m_acc_q : m_acc_q;
      mx  = (ai >= aq) ? ai : aq;
      mn  = (ai >= aq) ? aq : ai;
      mag = mx + (mn >> 2) + (mn >> 3);
      exp_i_q.push_back(m_acc_i[ACC_W-1:0]);
      exp_q_q.push_back(m_acc_q[ACC_W-1:0]);
      exp_mag_q.push_back(mag[ACC_W:0]);
      exp_cyc_q.push_back(cyc + 4);
      m_acc_i = 0;
      m_acc_q = 0;
      m_cnt   = 0;
    end
  endtask

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send(input int s, input bit sync);
    sample_in       = 16'(s);
    sample_valid_in = 1'b1;
    sync_in         = sync;
    model_accept(s, sync);
    @(posedge clk_in);
    #1;
    sample_valid_in = 1'b0;
    sync_in         = 1'b0;
  endtask

  task automatic sync_only();
    sync_in = 1'b1;
    model_clear();
    @(posedge clk_in);
    #1;
    sync_in = 1'b0;
  endtask

  task automatic send_tone(input int first, input int count, input int max_gap);
    for (int n = first; n < first + count; n++) begin
      idle(int'($urandom_range(max_gap, 0)));
      send(lut_m(n % 64), 1'b0);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_i_out"},     64'($unsigned(i_out)), 64'd0);
    check({tag, "_q_out"},     64'($unsigned(q_out)), 64'd0);
    check({tag, "_mag_out"},   64'(mag_out),          64'd0);
    check({tag, "_valid_out"}, 64'(valid_out),        64'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk_in) begin
    if (exp_cyc_q.size() > 0 && cyc == exp_cyc_q[0]) begin
      check("valid_out_pulse", 64'(valid_out), 64'd1);
      check("i_out",   64'($unsigned(i_out)), 64'(exp_i_q[0]));
      check("q_out",   64'($unsigned(q_out)), 64'(exp_q_q[0]));
      check("mag_out", 64'(mag_out),          64'(exp_mag_q[0]));
      void'(exp_i_q.pop_front());
      void'(exp_q_q.pop_front());
      void'(exp_mag_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end else if (valid_out) begin
      check("valid_out_timing", 64'(cyc),
            (exp_cyc_q.size() > 0) ? 64'(exp_cyc_q[0]) : 64'hFFFF_FFFF_FFFF_FFFF);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_in        = 1'b0;
    sample_in       = '0;
    sample_valid_in = 1'b0;
    sync_in         = 1'b0;
    model_clear();
    repeat (3) @(posedge clk_in);
    #1;
    check_zero_outputs("reset");
    rst_n_in = 1'b1;
    idle(2);

    // In-phase tone, continuous
    send_tone(0, 64, 0);
    idle(6);

    // DC input
    for (int n = 0; n < 64; n++) send(1000, 1'b0);
    idle(6);

    // Tone with random gaps
    send_tone(0, 64, 5);
    idle(6);

    // Partial window discarded by a bare sync
    send_tone(0, 20, 0);
    sync_only();
    send_tone(0, 64, 0);
    idle(6);

    // Sync coinciding with the first sample of the new window
    send_tone(0, 10, 0);
    send(lut_m(0), 1'b1);
    send_tone(1, 63, 0);
    idle(6);

    // Back-to-back windows
    send_tone(0, 128, 0);
    idle(6);

    // Sync on the edge that issues the completed window's pulse
    send_tone(0, 64, 0);
    idle(2);
    sync_only();
    send_tone(0, 64, 0);
    idle(6);

    // Asynchronous reset in the middle of a window
    send_tone(0, 30, 0);
    #3;
    rst_n_in = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    model_clear();
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    idle(2);
    send_tone(0, 64, 0);
    idle(10);

    check("queue_drained", 64'(exp_cyc_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
